// File: rtl/rf_read_port_arbiter.sv
// rf_read_port_arbiter
// Shares one register-file read path (32:1 mux tree) among NREQ requesters.
// Round-robin arbitration with valid/ready handshakes on request and response.
// Reads of register 0 always return zero.
// Optional build macro RF_ARB_PRIO0_EN: requester 0 gets fixed highest
// priority and the remaining requesters rotate among themselves.

module rf_read_port_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      req_ready,
    output logic [AW-1:0]        mux_sel,
    input  logic [DW-1:0]        mux_data,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [AW-1:0]   mux_sel_q, mux_sel_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic            accept_en;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic            accept;

    // New requests may be taken when idle, or when the current response is being consumed
    always_comb begin
        accept_en = 1'b0;
        if (rst_n) begin
            if (state_q == IDLE) begin
                accept_en = 1'b1;
            end else if (state_q == RESP && rsp_ready[gnt_q]) begin
                accept_en = 1'b1;
            end
        end
    end

    // Pick the winner: first valid requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin : winner_search
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
`ifdef RF_ARB_PRIO0_EN
        if (req_valid[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (!win_found && idx != 0 && req_valid[IW'(idx)]) begin
                    win_found = 1'b1;
                    win_idx   = IW'(idx);
                end
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && req_valid[IW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
`endif
    end

    assign accept = accept_en && win_found;

    // One-hot request ready for the winner in an accepting cycle
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Next-state logic for the transaction sequence and the datapath registers
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        mux_sel_d  = mux_sel_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ISSUE: begin
                rsp_data_d = (mux_sel_q == '0) ? '0 : mux_data;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d   = ISSUE;
            gnt_d     = win_idx;
            mux_sel_d = req_addr[int'(win_idx)*AW +: AW];
`ifdef RF_ARB_PRIO0_EN
            if (win_idx != '0) begin
                rr_ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
            end
`else
            rr_ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
`endif
        end
    end

    // State and datapath registers; reset drops any in-flight read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            mux_sel_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            mux_sel_q  <= mux_sel_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Response valid is held for the granted requester until it is consumed
    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[gnt_q] = 1'b1;
        end
    end

    assign mux_sel  = mux_sel_q;
    assign rsp_data = rsp_data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// Testbench for rf_read_port_arbiter (NREQ=4, DW=32, AW=5).
// Table-driven single reads plus hand sequences for round-robin,
// backpressure and asynchronous reset; responses are checked via a queue.

module tb_rf_read_port_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ-1:0]     req_ready;
    logic [AW-1:0]       mux_sel;
    logic [DW-1:0]       mux_data;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic [NREQ-1:0]     rsp_ready;
    logic                busy;

    rf_read_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .mux_sel   (mux_sel),
        .mux_data  (mux_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [DW-1:0]   data;
    } exp_t;

    typedef struct {
        logic [NREQ-1:0]    valid;
        logic [NREQ*AW-1:0] addrs;
        logic [DW-1:0]      mdata;
        logic [NREQ-1:0]    expGnt;
        logic [AW-1:0]      expSel;
        logic [DW-1:0]      expData;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[6];
    int   checkCount = 0;
    int   passCount  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [NREQ*AW-1:0] packAddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                                    input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                                 input logic [DW-1:0] md, input logic [NREQ-1:0] rr);
        req_valid = v;
        req_addr  = a;
        mux_data  = md;
        rsp_ready = rr;
    endtask

    // Check the grant of this cycle, record the expected response, retire a
    // completed response handshake, then advance to the next falling edge.
    task automatic stepCycle(input string tag, input logic [NREQ-1:0] expReady);
        logic [AW-1:0] a;
        exp_t          e;
        #1;
        checkOutput({tag, " req_ready"}, 32'(req_ready), 32'(expReady));
        if (expReady != '0) begin
            a = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (expReady[i]) a = req_addr[i*AW +: AW];
            end
            e.gnt  = expReady;
            e.data = (a == '0) ? '0 : mux_data;
            sbQ.push_back(e);
        end
        if ((rsp_valid & rsp_ready) != '0) begin
            if (sbQ.size() == 0) begin
                checkOutput({tag, " unexpected rsp_valid"}, 32'(rsp_valid), 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'(e.gnt));
                checkOutput({tag, " rsp_data"}, rsp_data, e.data);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus('0, '0, '0, '0);
        sbQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Bound the whole run in case the design wedges the sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    logic [NREQ-1:0] rrExp[5];

    initial begin
`ifdef RF_ARB_PRIO0_EN
        rrExp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        rrExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        vecs[0] = '{4'b0010, packAddr(5'd2, 5'd7, 5'd11, 5'd13), 32'hDEADBEEF, 4'b0010, 5'd7, 32'hDEADBEEF};
        vecs[1] = '{4'b0011, packAddr(5'd0, 5'd7, 5'd1, 5'd1), 32'h12345678, 4'b0001, 5'd0, 32'h00000000};
        vecs[2] = '{4'b1000, packAddr(5'd1, 5'd2, 5'd3, 5'd31), 32'hFFFFFFFF, 4'b1000, 5'd31, 32'hFFFFFFFF};
        vecs[3] = '{4'b0110, packAddr(5'd20, 5'd3, 5'd9, 5'd21), 32'hA5A5A5A5, 4'b0010, 5'd3, 32'hA5A5A5A5};
        vecs[4] = '{4'b0110, packAddr(5'd20, 5'd3, 5'd9, 5'd21), 32'h5A5A5A5A, 4'b0100, 5'd9, 32'h5A5A5A5A};
        vecs[5] = '{4'b0001, packAddr(5'd5, 5'd6, 5'd7, 5'd8), 32'h00000011, 4'b0001, 5'd5, 32'h00000011};

        // Reset values
        resetDut();
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset mux_sel", 32'(mux_sel), 32'd0);
        checkOutput("reset rsp_data", rsp_data, 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);

        // Table-driven single reads, each IDLE -> ISSUE -> RESP -> IDLE
        for (int n = 0; n < 6; n++) begin
            applyStimulus(vecs[n].valid, vecs[n].addrs, vecs[n].mdata, 4'b1111);
            stepCycle($sformatf("vec%0d accept", n), vecs[n].expGnt);
            checkOutput($sformatf("vec%0d mux_sel", n), 32'(mux_sel), 32'(vecs[n].expSel));
            checkOutput($sformatf("vec%0d busy", n), 32'(busy), 32'd1);
            req_valid = '0;
            stepCycle($sformatf("vec%0d issue", n), '0);
            checkOutput($sformatf("vec%0d rsp_valid direct", n), 32'(rsp_valid), 32'(vecs[n].expGnt));
            checkOutput($sformatf("vec%0d rsp_data direct", n), rsp_data, vecs[n].expData);
            stepCycle($sformatf("vec%0d resp", n), '0);
            checkOutput($sformatf("vec%0d idle busy", n), 32'(busy), 32'd0);
        end
        checkOutput("table sb empty", 32'(sbQ.size()), 32'd0);

        // Round-robin: all requesters held valid, accepts every other cycle
        resetDut();
        applyStimulus(4'b1111, packAddr(5'd1, 5'd2, 5'd3, 5'd4), 32'h00000100, 4'b1111);
        for (int c = 0; c < 10; c++) begin
            stepCycle($sformatf("rr cycle%0d", c), (c % 2 == 0) ? rrExp[c/2] : 4'b0000);
        end
        req_valid = '0;
        stepCycle("rr drain", '0);
        checkOutput("rr sb empty", 32'(sbQ.size()), 32'd0);

        // Backpressure: requester 2 withholds rsp_ready while 0 and 1 wait
        resetDut();
        applyStimulus(4'b0100, packAddr(5'd4, 5'd6, 5'd12, 5'd0), 32'hCAFE0002, 4'b1011);
        stepCycle("bp accept2", 4'b0100);
        req_valid = 4'b0011;
        stepCycle("bp issue", '0);
        mux_data = 32'h0BAD0BAD;
        for (int s = 0; s < 5; s++) begin
            checkOutput($sformatf("bp stall%0d rsp_valid", s), 32'(rsp_valid), 32'(4'b0100));
            checkOutput($sformatf("bp stall%0d rsp_data", s), rsp_data, 32'hCAFE0002);
            checkOutput($sformatf("bp stall%0d mux_sel", s), 32'(mux_sel), 32'd12);
            stepCycle($sformatf("bp stall%0d", s), '0);
        end
        rsp_ready = 4'b1111;
        mux_data  = 32'hBEEF0000;
        stepCycle("bp release", 4'b0001);
        req_valid = '0;
        stepCycle("bp issue0", '0);
        checkOutput("bp mux_sel0", 32'(mux_sel), 32'd4);
        stepCycle("bp resp0", '0);
        checkOutput("bp sb empty", 32'(sbQ.size()), 32'd0);

        // Asynchronous reset in the middle of a response
        resetDut();
        applyStimulus(4'b0001, packAddr(5'd3, 5'd8, 5'd9, 5'd10), 32'h00000033, 4'b0000);
        stepCycle("rst accept", 4'b0001);
        req_valid = '0;
        stepCycle("rst issue", '0);
        checkOutput("rst pre rsp_valid", 32'(rsp_valid), 32'(4'b0001));
        checkOutput("rst pre rsp_data", rsp_data, 32'h00000033);
        req_valid = 4'b0110;
        rst_n = 1'b0;
        #1;
        checkOutput("rst async rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst async rsp_data", rsp_data, 32'd0);
        checkOutput("rst async mux_sel", 32'(mux_sel), 32'd0);
        checkOutput("rst async busy", 32'(busy), 32'd0);
        checkOutput("rst async req_ready", 32'(req_ready), 32'd0);
        sbQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 4'b1111;
        stepCycle("rst after accept", 4'b0010);
        req_valid = '0;
        stepCycle("rst after issue", '0);
        stepCycle("rst after resp", '0);
        checkOutput("rst sb empty", 32'(sbQ.size()), 32'd0);
        checkOutput("rst final busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rf_read_port_arbiter.md
Name: rf_read_port_arbiter

Overview:
- Shares one 32-entry register-file read path among NREQ requesters (decode, debug, exception unit, ...).
- The read path is the 32:1 32-bit mux tree: this block drives its 5-bit select and captures its 32-bit output.
- Round-robin arbitration, per-requester valid/ready handshake on both request and response. $zero reads return 0.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, data width; matches mux tree width
AW, 5, register address width; matches mux select width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  request valid, one bit per requester
req_addr  input  NREQ*AW  register address; requester i at bits [i*AW +: AW]
req_ready  output  NREQ  request accepted this cycle (one-hot or zero)
mux_sel  output  AW  select to the 32:1 mux tree (registered)
mux_data  input  DW  dataout of the 32:1 mux tree
rsp_valid  output  NREQ  response valid for the granted requester (one-hot or zero)
rsp_data  output  DW  read data (registered)
rsp_ready  input  NREQ  response consumed
busy  output  1  state != IDLE

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, mux_sel=0, rsp_data=0, rsp_valid=0, req_ready=0, busy=0, rr_ptr=0, gnt_q=0.
- States:
  - IDLE: no transaction.
  - ISSUE: mux_sel is driven, and data is captured at the end of the cycle.
  - RESP: response is presented and held until consumed.
- Acceptance:
  - Allowed in IDLE, or in RESP in the same cycle rsp_ready[gnt_q]=1 (back-to-back).
  - Winner g is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g]=1 that cycle; it is combinational from req_valid and state, and never depends on req_addr.
  - On acceptance: mux_sel<=req_addr[g], gnt_q<=g, rr_ptr<=(g+1) mod NREQ, state<=ISSUE.
- ISSUE (1 cycle):
  - rsp_data<=(mux_sel==0) ? 0 : mux_data.
  - state<=RESP. No acceptance in this state.
- RESP:
  - rsp_valid[gnt_q]=1. rsp_data and mux_sel are held stable.
  - When rsp_ready[gnt_q]=1: if a new request is accepted, state<=ISSUE; otherwise state<=IDLE.
  - rsp_ready of non-granted bits is ignored.
- Latency: accept at cycle N, then rsp_valid at N+2. Throughput: one read per 2 cycles.
- Boundaries:
  - No valid requests: stay IDLE, rr_ptr unchanged.
  - Only one requester active: it wins every time regardless of rr_ptr.
  - rr_ptr wraps NREQ-1 -> 0.
  - A requester dropping req_valid without req_ready: no effect.
  - A requester holding rsp_ready=0: indefinite stall; all other requesters blocked (req_ready=0).
  - Address 31 selects the highest mux input. Address 0 forces rsp_data=0 even if mux_data!=0.
  - rst_n asserted mid-transaction: immediately return to reset values; the in-flight read is dropped and the requester must re-issue.

Optional Feature:
- RF_ARB_PRIO0_EN defined: requester 0 is the fixed highest priority; it wins whenever req_valid[0]=1. The others are round-robin among themselves, and rr_ptr updates only on non-zero grants.
- Undefined: pure round-robin across all NREQ requesters.

Test Plan:
- Reset: drive rst_n=0 mid-RESP with rsp_valid=0001 -> all outputs 0 asynchronously; after release, busy=0 and the first grant goes to the lowest valid index.
- Single read: req_valid=0010, addr1=7, mux_data=0xDEADBEEF -> req_ready=0010 at N, mux_sel=7 from N+1, rsp_valid=0010 and rsp_data=0xDEADBEEF at N+2.
- Round-robin: req_valid=1111 held, rsp_ready=1111 -> grant order 0,1,2,3,0 at accept cycles N, N+2, N+4, N+6, N+8.
- Backpressure: rsp_ready[2]=0 for 5 cycles during RESP while req_valid=0011 -> rsp_data and mux_sel stable, req_ready=0; grant to 0 on the cycle rsp_ready[2] rises.
- $zero: addr=0 with mux_data=0x12345678 -> rsp_data=0x00000000. Addr=31 with mux_data=0xFFFFFFFF -> rsp_data=0xFFFFFFFF.
- Macro: with RF_ARB_PRIO0_EN and req_valid=1111 held -> grants 0,0,0,...; with it undefined, grants rotate 0,1,2,3.
